dmem_wbuf_ctrl: RTL and testbench
=================================

DMEM_WBUF_CTRL -- requirements
Module: dmem_wbuf_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, write-buffer entries (power of 2, >=2).
REQ-002 Parameter: AW, 10, word-address width.
REQ-003 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low; clears all state immediately.
REQ-005 Port: cpu_addr  in  AW  CPU word address (driven by the CPU's d_addr).
REQ-006 Port: cpu_we  in  1  store request (driven by the CPU's we).
REQ-007 Port: cpu_re  in  1  load request (CPU is in MEM with a load).
REQ-008 Port: cpu_wdata  in  32  store data (driven by the CPU's out_data).
REQ-009 Port: cpu_rdata  out  32  load data (drives the CPU's in_data).
REQ-010 Port: cpu_hold  out  1  stall; high forces the CPU enable low.
REQ-011 Port: mem_req  out  1  external memory request.
REQ-012 Port: mem_we  out  1  1 = write, 0 = read.
REQ-013 Port: mem_addr  out  AW  external address.
REQ-014 Port: mem_wdata  out  32  external write data.
REQ-015 Port: mem_rdata  in  32  external read data; valid when mem_ack is high.
REQ-016 Port: mem_ack  in  1  transaction complete; sampled on clock.
REQ-017 Port: wb_count  out  log2(DEPTH)+1  number of occupied buffer entries.
REQ-018 Port: idle  out  1  high when the buffer is empty and the FSM is in IDLE.

Function
REQ-019 The write buffer SHALL be a circular FIFO with head/tail pointers that wrap modulo DEPTH and a separate count for full/empty.
REQ-020 A store (cpu_we=1, hold=0) SHALL push {cpu_addr, cpu_wdata} at the clock edge with zero stall cycles when count<DEPTH.
REQ-021 When count==DEPTH and cpu_we=1, cpu_hold SHALL be 1 combinationally, and the push SHALL occur on the first edge where registered count<DEPTH; a same-cycle pop SHALL NOT bypass.
REQ-022 Load hit: cpu_re=1 and any valid entry matches cpu_addr -> cpu_rdata SHALL be the youngest matching entry in the same cycle, with cpu_hold=0.
REQ-023 Load miss -> cpu_hold=1 until data returns; the FSM SHALL issue the read, and the read SHALL bypass older non-matching buffered writes.
REQ-024 The FSM SHALL have states IDLE, RD, WR and RDONE.
REQ-025 FSM transitions from IDLE: load miss pending -> RD (priority); else count>0 -> WR; else stay in IDLE.
REQ-026 FSM transitions from RD: on mem_ack, capture mem_rdata into rd_buf and go to RDONE.
REQ-027 FSM transition from RDONE: cpu_rdata=rd_buf, cpu_hold=0 for exactly one cycle, then go to IDLE.
REQ-028 FSM transition from WR: on mem_ack, pop the head and go to IDLE.
REQ-029 Handshake: mem_req=1 exactly in RD/WR; mem_we, mem_addr and mem_wdata SHALL be stable while mem_req=1; mem_req SHALL drop the cycle after ack; one outstanding transaction maximum.
REQ-030 In RD, mem_we=0, mem_addr=cpu_addr latched on entry, and mem_wdata=0.
REQ-031 In WR, mem_we=1 and addr/data come from the head entry.
REQ-032 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-033 If cpu_we and cpu_re are both 1, the store SHALL be taken, the load SHALL be ignored, and cpu_rdata SHALL be 0.
REQ-034 cpu_rdata SHALL be 0 when there is no load or the load is stalled.
REQ-035 mem_ack outside RD/WR SHALL be ignored.
REQ-036 wb_count SHALL equal the registered count.

Reset
REQ-037 On reset low, state=IDLE, count=0, pointers=0, rd_buf=0, and every output SHALL be 0 except idle=1, effective asynchronously.
REQ-038 Reset mid-transaction SHALL drop mem_req immediately and discard buffered stores.

Verification
REQ-039 Store 0xDEADBEEF to @5, then load @5 the next cycle -> cpu_rdata=0xDEADBEEF same cycle, hold=0, no mem read issued.
REQ-040 Five stores (DEPTH=4) with mem_ack held low -> hold=1 on the 5th and wb_count=4; one ack -> the 5th store is accepted the following edge and drain order is preserved.
REQ-041 Buffered store @3, then load @7 (memory holds 0x1234) with ack latency 3 -> RD is issued before WR, hold for 4 cycles, then cpu_rdata=0x1234 for one cycle.
REQ-042 Stores @9=1 then @9=2, then load @9 -> cpu_rdata=2.
REQ-043 Reset asserted while mem_req=1 in WR -> mem_req=0 without waiting for a clock, wb_count=0, idle=1.
REQ-044 Both cpu_we and cpu_re high -> store buffered, cpu_rdata=0, no read issued.

Source files
------------

// File: rtl/dmem_wbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_wbuf_ctrl
// Description : Data-memory controller with a posted write buffer.
//               CPU stores are posted into a circular FIFO and drained to
//               external memory in the background. CPU loads are served
//               directly from the buffer when the address matches a pending
//               store (youngest entry wins). Otherwise the load stalls the
//               CPU and goes to memory ahead of any queued writes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   cpu_addr   in   CPU word address
//   cpu_we     in   CPU store request
//   cpu_re     in   CPU load request
//   cpu_wdata  in   CPU store data
//   cpu_rdata  out  CPU load data (0 when no load is being returned)
//   cpu_hold   out  CPU stall
//   mem_req    out  external request (high in RD / WR only)
//   mem_we     out  external write strobe
//   mem_addr   out  external word address
//   mem_wdata  out  external write data
//   mem_rdata  in   external read data, valid with mem_ack
//   mem_ack    in   external transaction complete
//   wb_count   out  occupied write-buffer entries
//   idle       out  buffer empty and FSM in IDLE
// ============================================================================
module dmem_wbuf_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [AW-1:0]          cpu_addr,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_hold,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_ack,
  output logic [$clog2(DEPTH):0] wb_count,
  output logic                   idle
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_RDONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  // Write-buffer storage and bookkeeping
  logic [AW-1:0]   r_buf_addr [DEPTH];
  logic [31:0]     r_buf_data [DEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;

  // Load-miss bookkeeping
  logic [31:0]     r_rd_buf;
  logic [AW-1:0]   r_rd_addr;

  logic            w_full;
  logic            w_load;
  logic            w_hit;
  logic [31:0]     w_hit_data;
  logic            w_miss;
  logic            w_push;
  logic            w_pop;
  logic            w_rd_start;
  logic            w_hold;
  logic [31:0]     w_rdata;

  // A store wins over a simultaneous load; the load is simply ignored.
  assign w_full = (r_count == c_FULL);
  assign w_load = cpu_re & ~cpu_we;

  // Full check uses the registered count only, so a pop in the same cycle
  // never lets a store slip into a full buffer.
  assign w_push = cpu_we & ~w_full;

  // Store-to-load forwarding. Entries are scanned oldest to youngest from
  // the head so the last match (youngest store) is the one returned.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((c_CW'(k) < r_count) &&
          (r_buf_addr[r_head + c_PW'(k)] == cpu_addr)) begin
        w_hit      = 1'b1;
        w_hit_data = r_buf_data[r_head + c_PW'(k)];
      end
    end
  end

  assign w_miss = w_load & ~w_hit;

  // Next-state logic. A pending load miss takes priority over draining,
  // which lets the read overtake older buffered writes. This is safe
  // because a miss by definition matches none of them.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rd_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_state_nxt = ST_RD;
          w_rd_start  = 1'b1;
        end else if (r_count != '0) begin
          w_state_nxt = ST_WR;
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          w_state_nxt = ST_RDONE;
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RDONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // CPU-side response. A missing load remains stalled until RDONE, where the
  // captured read data is presented for exactly one cycle.
  always_comb begin
    w_hold  = 1'b0;
    w_rdata = '0;
    if (cpu_we) begin
      w_hold = w_full;
    end else if (cpu_re) begin
      if (w_hit) begin
        w_rdata = w_hit_data;
      end else if (r_state == ST_RDONE) begin
        w_rdata = r_rd_buf;
      end else begin
        w_hold = 1'b1;
      end
    end
  end

  // CPU outputs are forced low while reset is asserted, regardless of
  // what the CPU is driving.
  assign cpu_hold  = w_hold & reset;
  assign cpu_rdata = reset ? w_rdata : 32'h0;

  // Memory-side outputs are pure functions of the state and the latched
  // address or head entry, so they hold steady for the whole request.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_RD: begin
        mem_req  = 1'b1;
        mem_addr = r_rd_addr;
      end
      ST_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_buf_addr[r_head];
        mem_wdata = r_buf_data[r_head];
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign wb_count = r_count;
  assign idle     = (r_count == '0) && (r_state == ST_IDLE);

  // Control state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_rd_buf  <= '0;
      r_rd_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_tail <= r_tail + c_PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_rd_start) begin
        r_rd_addr <= cpu_addr;
      end
      if ((r_state == ST_RD) && mem_ack) begin
        r_rd_buf <= mem_rdata;
      end
    end
  end

  // Buffer payload. It needs no reset because r_count gates every read.
  always_ff @(posedge clock) begin
    if (w_push && reset) begin
      r_buf_addr[r_tail] <= cpu_addr;
      r_buf_data[r_tail] <= cpu_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_wbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_wbuf_ctrl
// Description : Scoreboard bench for dmem_wbuf_ctrl. Stimulus pushes
//               hand-computed expected memory transactions and load data
//               into queues. A monitor pops and compares each queue entry
//               when the DUT completes the matching transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_wbuf_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic          cpu_re;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_hold;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic [2:0]    wb_count;
  logic          idle;

  dmem_wbuf_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_hold  (cpu_hold),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .wb_count  (wb_count),
    .idle      (idle)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } txn_t;

  txn_t        exp_mem[$];
  logic [31:0] exp_load[$];
  logic [31:0] mem_model [0:1023];
  int          lat       = 1;
  bit          ack_block = 1'b0;
  int          n_cmp     = 0;
  int          n_err     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks on the lat-th cycle of a request.
  initial begin
    int cnt = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem_model[i] = '0;
    forever begin
      @(negedge clock);
      if (mem_req && !ack_block) begin
        if (cnt + 1 >= lat) begin
          mem_ack = 1'b1;
          cnt     = 0;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            mem_rdata           = '0;
          end else begin
            mem_rdata = mem_model[mem_addr];
          end
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cnt       = 0;
      end
    end
  end

  // Monitor: compares completed loads and memory transactions.
  initial begin
    txn_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset && cpu_re && !cpu_we && !cpu_hold) begin
        if (exp_load.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL load_unexpected: got 0x%08h expected none", cpu_rdata);
        end else begin
          chk("load_rdata", cpu_rdata, exp_load.pop_front());
        end
      end else begin
        chk("rdata_zero", cpu_rdata, 32'h0);
      end
      if (mem_req && mem_ack) begin
        if (exp_mem.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL mem_unexpected: got we=%0b addr=0x%03h data=0x%08h expected none",
                   mem_we, mem_addr, mem_wdata);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_wdata", mem_wdata, e.data);
        end
      end
    end
  end

  // Issue one CPU operation at posedge+1 and hold it until accepted.
  // Returns the number of stalled cycles and the data seen on acceptance.
  task automatic do_op(input logic we, input logic re, input logic [AW-1:0] addr,
                       input logic [31:0] data, output int holds, output logic [31:0] rd);
    bit done = 1'b0;
    cpu_we    = we;
    cpu_re    = re;
    cpu_addr  = addr;
    cpu_wdata = data;
    holds     = 0;
    rd        = '0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      #2;
      if (!cpu_hold) begin
        done = 1'b1;
        rd   = cpu_rdata;
      end else begin
        holds++;
      end
      @(posedge clock);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL op_timeout: hold=%0b expected 0", cpu_hold);
    end
    cpu_we = 1'b0;
    cpu_re = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      #2;
      if (idle) ok = 1'b1;
      @(posedge clock);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_idle_timeout: idle=%0b expected 1", name, idle);
    end
    chk({name, "_mem_q_left"}, 32'(exp_mem.size()), 32'h0);
    chk({name, "_load_q_left"}, 32'(exp_load.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          h;
    logic [31:0] rd;
    bit          seen;

    reset     = 1'b0;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2;
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_wb_count", 32'(wb_count), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Store then immediate load of the same address: forwarded, no read
    lat = 1;
    exp_mem.push_back(txn_t'{we: 1'b1, addr: 10'd5, data: 32'hDEADBEEF});
    exp_load.push_back(32'hDEADBEEF);
    do_op(1'b1, 1'b0, 10'd5, 32'hDEADBEEF, h, rd);
    chk("fwd_store_holds", 32'(h), 32'h0);
    do_op(1'b0, 1'b1, 10'd5, 32'h0, h, rd);
    chk("fwd_load_holds", 32'(h), 32'h0);
    chk("fwd_load_data", rd, 32'hDEADBEEF);
    wait_idle("fwd");

    // Two stores to the same address: youngest is forwarded
    lat = 2;
    exp_mem.push_back(txn_t'{we: 1'b1, addr: 10'd9, data: 32'h1});
    exp_mem.push_back(txn_t'{we: 1'b1, addr: 10'd9, data: 32'h2});
    exp_load.push_back(32'h2);
    do_op(1'b1, 1'b0, 10'd9, 32'h1, h, rd);
    do_op(1'b1, 1'b0, 10'd9, 32'h2, h, rd);
    do_op(1'b0, 1'b1, 10'd9, 32'h0, h, rd);
    chk("young_load_holds", 32'(h), 32'h0);
    chk("young_load_data", rd, 32'h2);
    wait_idle("young");

    // Store and load together: store taken, load ignored
    lat = 1;
    exp_mem.push_back(txn_t'{we: 1'b1, addr: 10'h20, data: 32'hA5A5A5A5});
    do_op(1'b1, 1'b1, 10'h20, 32'hA5A5A5A5, h, rd);
    chk("both_holds", 32'(h), 32'h0);
    chk("both_rdata", rd, 32'h0);
    wait_idle("both");

    // Load miss overtakes a buffered write; ack latency 3
    lat = 3;
    mem_model[7] = 32'h1234;
    exp_mem.push_back(txn_t'{we: 1'b0, addr: 10'd7, data: 32'h0});
    exp_mem.push_back(txn_t'{we: 1'b1, addr: 10'd3, data: 32'h55});
    exp_load.push_back(32'h1234);
    do_op(1'b1, 1'b0, 10'd3, 32'h55, h, rd);
    chk("miss_store_holds", 32'(h), 32'h0);
    do_op(1'b0, 1'b1, 10'd7, 32'h0, h, rd);
    chk("miss_load_holds", 32'(h), 32'h4);
    chk("miss_load_data", rd, 32'h1234);
    wait_idle("miss");

    // Full buffer: fifth store stalls until one drain completes
    lat       = 1;
    ack_block = 1'b1;
    for (int i = 0; i < 5; i++)
      exp_mem.push_back(txn_t'{we: 1'b1, addr: 10'(10'h10 + i), data: 32'(32'h100 + i)});
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 1'b0, 10'(10'h10 + i), 32'(32'h100 + i), h, rd);
      chk("full_fill_holds", 32'(h), 32'h0);
    end
    fork
      do_op(1'b1, 1'b0, 10'h14, 32'h104, h, rd);
      begin
        @(negedge clock);
        #2;
        chk("full_hold", 32'(cpu_hold), 32'h1);
        chk("full_wb_count", 32'(wb_count), 32'h4);
        ack_block = 1'b0;
      end
    join
    chk("full_fifth_holds", 32'(h), 32'h2);
    wait_idle("full");

    // Reset asserted during a write: mem_req drops without a clock edge
    ack_block = 1'b1;
    do_op(1'b1, 1'b0, 10'h30, 32'h77, h, rd);
    do_op(1'b1, 1'b0, 10'h31, 32'h88, h, rd);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      #2;
      if (mem_req) seen = 1'b1;
    end
    chk("arst_req_before", 32'(mem_req), 32'h1);
    reset = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'h0);
    chk("arst_mem_we", 32'(mem_we), 32'h0);
    chk("arst_mem_addr", 32'(mem_addr), 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    chk("arst_wb_count", 32'(wb_count), 32'h0);
    chk("arst_idle", 32'(idle), 32'h1);
    ack_block = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("arst_after_count", 32'(wb_count), 32'h0);
    wait_idle("arst");

    // Top-of-range address: forwarded hit, then miss read after drain
    lat = 2;
    exp_mem.push_back(txn_t'{we: 1'b1, addr: 10'h3FF, data: 32'hCAFEF00D});
    exp_load.push_back(32'hCAFEF00D);
    do_op(1'b1, 1'b0, 10'h3FF, 32'hCAFEF00D, h, rd);
    do_op(1'b0, 1'b1, 10'h3FF, 32'h0, h, rd);
    chk("top_hit_holds", 32'(h), 32'h0);
    chk("top_hit_data", rd, 32'hCAFEF00D);
    wait_idle("top_hit");
    lat = 1;
    exp_mem.push_back(txn_t'{we: 1'b0, addr: 10'h3FF, data: 32'h0});
    exp_load.push_back(32'hCAFEF00D);
    do_op(1'b0, 1'b1, 10'h3FF, 32'h0, h, rd);
    chk("top_miss_holds", 32'(h), 32'h2);
    chk("top_miss_data", rd, 32'hCAFEF00D);
    wait_idle("top_miss");

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
